// File: rtl/serial_bit_feeder_pkg.sv
// Shared FSM encoding and default timing constants for the feeder and the detector.
package serial_bit_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CLK_HZ      = 100_000_000;
    localparam int DEBOUNCE_MS = 10;
    localparam int TICK_MS     = 1000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-time debounce, one-cycle rise pulse.
// rise_pulse is asserted in the same cycle the debounced level first reads 1.
module button_debounce
    import serial_bit_feeder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          flip;

    // cnt holds how many consecutive cycles sync2 has disagreed with level, minus one
    assign flip = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            cnt        <= '0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= btn_in;
            sync2      <= sync1;
            rise_pulse <= flip && !level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// Latches switch bits on a debounced press and emits them LSB first, one per tick.
// A press while shifting aborts the running sequence and reloads from the switches.
module serial_bit_feeder
    import serial_bit_feeder_pkg::*;
#(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
    parameter int TICK_CYCLES     = ms_to_cycles(TICK_MS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       button,
    input  logic [NBITS-1:0]           switch,
    output logic                       start_pulse,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic [$clog2(NBITS+0)-0:0] bit_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int IW = $clog2(NBITS) + 1;
    localparam int TW = $clog2(TICK_CYCLES);

    logic             db_level;
    logic             db_rise;
    logic             press;
    state_t           state;
    state_t           nxt;
    logic             load;
    logic             emit;
    logic             tick_term;
    logic             last_bit;
    logic [NBITS-1:0] shreg;
    logic [TW-1:0]    tick;
    logic [IW-1:0]    sent;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (button),
        .level     (db_level),
        .rise_pulse(db_rise)
    );

    assign press     = db_rise && db_level;
    assign tick_term = (tick == TW'(TICK_CYCLES - 1));
    assign last_bit  = (sent == IW'(NBITS - 1));

    always_comb begin
        nxt  = state;
        load = 1'b0;
        emit = 1'b0;
        case (state)
            IDLE:  if (press) nxt = LOAD;
            LOAD: begin
                load = 1'b1;
                nxt  = SHIFT;
            end
            // a press outranks a coincident terminal count
            SHIFT: begin
                if (press) begin
                    nxt = LOAD;
                end else if (tick_term) begin
                    emit = 1'b1;
                    if (last_bit) nxt = DONE;
                end
            end
            DONE:  if (press) nxt = LOAD;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pulse <= 1'b0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            bit_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            shreg       <= '0;
            tick        <= '0;
            sent        <= '0;
        end else begin
            start_pulse <= load;
            bit_valid   <= emit;
            busy        <= (nxt == LOAD) || (nxt == SHIFT);
            done        <= (nxt == DONE);
            if (load) begin
                shreg   <= switch;
                bit_idx <= '0;
                tick    <= '0;
                sent    <= '0;
            end else if (state == SHIFT) begin
                tick <= tick_term ? '0 : tick + 1'b1;
                if (emit) begin
                    bit_out <= shreg[0];
                    bit_idx <= sent;
                    sent    <= sent + 1'b1;
                    shreg   <= shreg >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder with short debounce and tick periods.
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button;
    logic [7:0] sw;
    logic       start_pulse, bit_out, bit_valid, busy, done;
    logic [3:0] bit_idx;

    typedef struct {
        int         cyc;
        logic       b;
        logic [3:0] idx;
        logic       dn;
    } ev_t;

    ev_t ev_q[$];
    int  sp_q[$];
    ev_t ev;
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_mis = 0;
    int  first;

    serial_bit_feeder #(
        .NBITS          (8),
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .switch     (sw),
        .start_pulse(start_pulse),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_idx    (bit_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // log strobes and start pulses mid-cycle, stamped with a cycle count
    always @(negedge clk) begin
        cyc++;
        if (bit_valid === 1'b1) begin
            ev.cyc = cyc;
            ev.b   = bit_out;
            ev.idx = bit_idx;
            ev.dn  = done;
            ev_q.push_back(ev);
        end
        if (start_pulse === 1'b1) sp_q.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] val, input int hold);
        sw     = val;
        button = 1'b1;
        step(hold);
        button = 1'b0;
    endtask

    task automatic wait_ev(input int n, input int budget);
        for (int i = 0; i < budget && ev_q.size() < n; i++) step(1);
        chk("wait_strobes", 32'(ev_q.size() >= n), 1);
    endtask

    task automatic wait_sp(input int n, input int budget);
        for (int i = 0; i < budget && sp_q.size() < n; i++) step(1);
        chk("wait_start", 32'(sp_q.size() >= n), 1);
    endtask

    task automatic check_seq(input string tag, input logic [7:0] exp, input int sp_idx, input int base);
        int prev;
        chk({tag, "_count"}, 32'(ev_q.size() >= base + 8), 1);
        prev = (sp_q.size() > sp_idx) ? sp_q[sp_idx] : -100;
        for (int k = 0; k < 8 && base + k < ev_q.size(); k++) begin
            chk({tag, "_gap"}, 32'(ev_q[base+k].cyc - prev), 5);
            chk({tag, "_bit"}, 32'(ev_q[base+k].b), 32'(exp[k]));
            chk({tag, "_idx"}, 32'(ev_q[base+k].idx), 32'(k));
            chk({tag, "_done"}, 32'(ev_q[base+k].dn), 32'(k == 7));
            prev = ev_q[base+k].cyc;
        end
    endtask

    task automatic clear_logs();
        ev_q.delete();
        sp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] old_bits;
        rst_n  = 1'b0;
        button = 1'b0;
        sw     = 8'h00;
        step(3);
        chk("rst_start_pulse", 32'(start_pulse), 0);
        chk("rst_bit_out", 32'(bit_out), 0);
        chk("rst_bit_valid", 32'(bit_valid), 0);
        chk("rst_bit_idx", 32'(bit_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        step(2);

        // two-cycle glitch must never reach the stable count
        clear_logs();
        press(8'hFF, 2);
        step(20);
        chk("glitch_starts", 32'(sp_q.size()), 0);
        chk("glitch_busy", 32'(busy), 0);

        // normal run
        clear_logs();
        press(8'b1011_0010, 10);
        wait_ev(8, 200);
        step(3);
        chk("norm_starts", 32'(sp_q.size()), 1);
        chk("norm_strobes", 32'(ev_q.size()), 8);
        check_seq("norm", 8'b1011_0010, 0, 0);
        chk("norm_done", 32'(done), 1);
        chk("norm_busy", 32'(busy), 0);
        chk("norm_idx_hold", 32'(bit_idx), 7);

        // restart in the middle of a run
        clear_logs();
        press(8'b1011_0010, 10);
        wait_ev(3, 200);
        press(8'hFF, 10);
        wait_sp(2, 50);
        first = 0;
        foreach (ev_q[i]) if (sp_q.size() > 1 && ev_q[i].cyc < sp_q[1]) first++;
        chk("rst_old_cnt", 32'(first >= 3 && first < 8), 1);
        old_bits = 8'b1011_0010;
        for (int i = 0; i < first; i++) chk("restart_old_bit", 32'(ev_q[i].b), 32'(old_bits[i]));
        wait_ev(first + 8, 200);
        step(3);
        chk("restart_starts", 32'(sp_q.size()), 2);
        check_seq("restart", 8'hFF, 1, first);
        chk("restart_done", 32'(done), 1);

        // switch changes after load are ignored
        clear_logs();
        press(8'h0F, 10);
        wait_sp(1, 50);
        sw = 8'hF0;
        wait_ev(8, 200);
        step(3);
        check_seq("swchg", 8'h0F, 0, 0);

        // long hold gives one start only
        clear_logs();
        press(8'h5A, 200);
        step(20);
        chk("hold_starts", 32'(sp_q.size()), 1);
        chk("hold_strobes", 32'(ev_q.size()), 8);
        check_seq("hold", 8'h5A, 0, 0);
        chk("hold_done", 32'(done), 1);

        // clean re-press from DONE
        clear_logs();
        press(8'h3C, 10);
        chk("repress_done_drop", 32'(done), 0);
        chk("repress_busy", 32'(busy), 1);
        wait_ev(8, 200);
        step(3);
        check_seq("repress", 8'h3C, 0, 0);

        // asynchronous reset in the middle of shifting
        clear_logs();
        press(8'hAA, 10);
        wait_ev(2, 200);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_start_pulse", 32'(start_pulse), 0);
        chk("midrst_bit_out", 32'(bit_out), 0);
        chk("midrst_bit_valid", 32'(bit_valid), 0);
        chk("midrst_bit_idx", 32'(bit_idx), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        step(2);
        rst_n = 1'b1;
        clear_logs();
        step(50);
        chk("midrst_no_strobe", 32'(ev_q.size()), 0);
        chk("midrst_no_start", 32'(sp_q.size()), 0);
        chk("midrst_busy_after", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Upstream stage of the sequence detector.
- Turns a raw push-button press into one clean start event and latches the 8 switch bits at that moment.
- Sends the latched bits out serially, LSB first, one bit per slow tick, each with a one-cycle valid strobe.
- Gives the detector a start pulse, a current bit index and completion status, replacing ad-hoc timer/mux indexing.

Parameters:
- NBITS, 8: number of bits latched and sent.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed before the debounced button level changes (10 ms at 100 MHz).
- TICK_CYCLES, 100_000_000: clock cycles between successive bits (1 s at 100 MHz); legal range ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- button  in  1  raw, asynchronous push-button level
- switch  in  NBITS  parallel bits, sampled only at start
- start_pulse  out  1  one-cycle pulse when a new sequence is loaded
- bit_out  out  1  current serial bit; holds its value between strobes
- bit_valid  out  1  one-cycle strobe, bit_out is new this cycle
- bit_idx  out  $clog2(NBITS)+1  index of the bit on bit_out (0..NBITS-1)
- busy  out  1  high while a sequence is loaded or shifting
- done  out  1  high after the last bit until the next press or reset

Behaviour:
- Reset (rst_n=0, async): all outputs 0, FSM in IDLE, shift register, counters and debounce state cleared. Same response mid-operation; no strobe is emitted after reset asserts.
- Button conditioning:
  - 2-FF synchronizer, then debounce counter.
  - The debounced level flips only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A rising edge of the debounced level gives exactly one internal press cycle, however long the button is held.
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are registered.
  - IDLE: busy=0. On press, go to LOAD.
  - LOAD (1 cycle): shift register <= switch, bit_idx <= 0, tick counter <= 0, done <= 0; start_pulse=1 on the next cycle. Go to SHIFT.
  - SHIFT: busy=1. The tick counter counts 0..TICK_CYCLES-1. At terminal count:
    - bit_out <= shreg[0], bit_valid=1 for one cycle, bit_idx <= ordinal of that bit, shreg shifts right, counter wraps to 0.
    - When the NBITS-th bit is emitted, go to DONE.
  - DONE: busy=0, done=1 (held). On press, go to LOAD.
- Latency: first bit_valid comes TICK_CYCLES cycles after start_pulse; consecutive strobes are exactly TICK_CYCLES apart.
- Press during SHIFT: abort and go to LOAD with the current switch value; no strobe that cycle. If a press and a terminal count coincide, the press wins.
- Switch changes after LOAD are ignored for the running sequence.
- bit_idx never exceeds NBITS-1; it stays at NBITS-1 in DONE and returns to 0 on LOAD.
- Counter widths are $clog2 of their parameter. All arithmetic is unsigned; no overflow is possible within the legal parameter range.

Decomposition:
- Shared package:
  - FSM state encoding localparams (IDLE/LOAD/SHIFT/DONE).
  - Default timing constants CLK_HZ, DEBOUNCE_MS, TICK_MS. The detector reuses these.
- Sub-module: button_debounce (synchronizer, debounce counter, rising-edge pulse); parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_in, level, rise_pulse.
- FSM, tick counter and shift register stay in the top.

Test Plan (NBITS=8, DEBOUNCE_CYCLES=4, TICK_CYCLES=5):
- Reset: rst_n=0 mid-SHIFT -> all outputs 0 within the same cycle, no bit_valid for 50 cycles after release, busy=0.
- Glitch: button high for 2 cycles then low -> no start_pulse, busy stays 0.
- Normal run: switch=8'b1011_0010, button held 10 cycles ->
  - one start_pulse;
  - 8 bit_valid strobes, exactly 5 cycles apart, bit_out = 0,1,0,0,1,1,0,1;
  - bit_idx = 0..7;
  - done=1 after the 8th strobe, busy=0.
- Restart: during the run above, after the 3rd strobe, set switch=8'hFF and press -> new start_pulse, 8 strobes all 1, bit_idx restarts at 0, done only after the new 8th strobe.
- Switch change ignored: load 8'h0F, toggle switch to 8'hF0 during SHIFT -> bits 1,1,1,1,0,0,0,0.
- Long hold / re-press: button held 200 cycles -> exactly one start_pulse. A second clean press from DONE -> done drops, new sequence starts.
